// File: rtl/execute_pkg.sv
// Shared types for the RV32I/M execute stage: ALU, branch, forwarding and
// mul/div encodings plus small decode helpers for the mul/div operations.
package execute_pkg;

    localparam int ALU_OP_W = 4;
    localparam int MD_OP_W  = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input muldiv_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_a_signed(input muldiv_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input muldiv_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: magnitudes in, one shift-add or
// restoring-subtract step per cycle, sign correction on the way out.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [MD_OP_W-1:0]  op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     result
);
    localparam int CW = $clog2(XLEN);

    md_state_e         state_d, state_q;
    logic [CW-1:0]     count_d, count_q;
    muldiv_op_e        op_d, op_q;
    logic [XLEN-1:0]   hi_d, hi_q, lo_d, lo_q, dv_d, dv_q;
    logic              a_neg_d, a_neg_q, b_neg_d, b_neg_q, b_zero_d, b_zero_q;

    muldiv_op_e        op_in;
    logic              a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign op_in    = muldiv_op_e'(op);
    assign a_neg_in = md_a_signed(op_in) & a[XLEN-1];
    assign b_neg_in = md_b_signed(op_in) & b[XLEN-1];
    assign a_mag    = a_neg_in ? -a : a;
    assign b_mag    = b_neg_in ? -b : b;

    // hi:lo is the product accumulator for multiply and remainder:quotient for divide.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dv_q};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dv_d     = dv_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        case (state_q)
            MD_IDLE: begin
                if (start && !abort) begin
                    state_d  = MD_BUSY;
                    count_d  = CW'(XLEN - 1);
                    op_d     = op_in;
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
                    b_zero_d = (b == '0);
                    hi_d     = '0;
                    lo_d     = md_is_div(op_in) ? a_mag : b_mag;
                    dv_d     = md_is_div(op_in) ? b_mag : a_mag;
                end
            end
            MD_BUSY: begin
                if (abort) begin
                    state_d = MD_IDLE;
                end else begin
                    if (md_is_div(op_q)) begin
                        hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (count_q == '0) state_d = MD_DONE;
                    else               count_d = count_q - CW'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Signed overflow needs no special case: |-2^(XLEN-1)| / 1 already yields the dividend.
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo_s  = b_zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -lo_q : lo_q);
        rem_s  = a_neg_q ? -hi_q : hi_q;
        case (op_q)
            MD_MUL:                        result = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               result = quo_s;
            default:                       result = rem_s;
        endcase
    end

    // Busy means "no result to hand over yet", so it is also high in IDLE.
    assign busy = (state_q != MD_DONE);
    assign done = (state_q == MD_DONE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            op_q     <= MD_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dv_q     <= dv_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I/M execute stage: forwarding muxes, ALU, branch resolution, optional
// iterative mul/div, and the E->M pipeline register with stall/flush bubbles.
module execute_stage
    import execute_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAW       = 5,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteE,
    input  logic                MemWriteE,
    input  logic                BranchE,
    input  logic                JumpE,
    input  logic                JalrE,
    input  logic                ALUSrcE,
    input  logic                MulDivE,
    input  logic [1:0]          ResultSrcE,
    input  logic [ALU_OP_W-1:0] ALUControlE,
    input  logic [2:0]          Funct3E,
    input  logic [XLEN-1:0]     RD1_E,
    input  logic [XLEN-1:0]     RD2_E,
    input  logic [XLEN-1:0]     Imm_Ext_E,
    input  logic [XLEN-1:0]     PCE,
    input  logic [XLEN-1:0]     PCPlus4E,
    input  logic [RAW-1:0]      RD_E,
    input  logic [1:0]          ForwardAE,
    input  logic [1:0]          ForwardBE,
    input  logic [XLEN-1:0]     ResultW,
    input  logic                FlushE,
    output logic [XLEN-1:0]     PCTargetE,
    output logic                PCSrcE,
    output logic                StallE,
    output logic                RegWriteM,
    output logic                MemWriteM,
    output logic [1:0]          ResultSrcM,
    output logic [RAW-1:0]      RD_M,
    output logic [XLEN-1:0]     PCPlus4M,
    output logic [XLEN-1:0]     WriteDataM,
    output logic [XLEN-1:0]     ALU_ResultM
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, md_result, jalr_sum;
    logic [SHW-1:0]  shamt;
    logic            cond_taken, md_busy, md_done, bubble;

    logic            reg_write_d, reg_write_q, mem_write_d, mem_write_q;
    result_src_e     result_src_d, result_src_q;
    logic [RAW-1:0]  rd_d, rd_q;
    logic [XLEN-1:0] pc_plus4_d, pc_plus4_q, write_data_d, write_data_q;
    logic [XLEN-1:0] alu_result_d, alu_result_q;

    always_comb begin
        case (fwd_sel_e'(ForwardAE))
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
        case (fwd_sel_e'(ForwardBE))
            FWD_W:   fwd_b = ResultW;
            FWD_M:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        case (alu_op_e'(ALUControlE))
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
            default:  alu_result = '0;
        endcase
    end

    // Branches compare the forwarded register operands, never the immediate.
    always_comb begin
        case (br_cond_e'(Funct3E))
            BR_EQ:   cond_taken = (src_a == fwd_b);
            BR_NE:   cond_taken = (src_a != fwd_b);
            BR_LT:   cond_taken = ($signed(src_a) <  $signed(fwd_b));
            BR_GE:   cond_taken = ($signed(src_a) >= $signed(fwd_b));
            BR_LTU:  cond_taken = (src_a <  fwd_b);
            BR_GEU:  cond_taken = (src_a >= fwd_b);
            default: cond_taken = 1'b0;
        endcase
    end

    assign jalr_sum  = src_a + Imm_Ext_E;
    assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : PCE + Imm_Ext_E;

    generate
        if (MULDIV_EN) begin : gen_muldiv
            muldiv_iter #(.XLEN(XLEN)) u_muldiv (
                .clk    (clk),
                .rst    (rst),
                .start  (MulDivE),
                .abort  (FlushE),
                .op     (Funct3E),
                .a      (src_a),
                .b      (fwd_b),
                .busy   (md_busy),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : gen_no_muldiv
            assign md_busy   = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    assign StallE = rst & MulDivE & md_busy;
    assign PCSrcE = rst & ~StallE & ((BranchE & cond_taken) | JumpE | JalrE);

    // Stall and flush both squash the architectural side effects; data fields pass through.
    always_comb begin
        bubble       = StallE | FlushE;
        reg_write_d  = RegWriteE & ~bubble;
        mem_write_d  = MemWriteE & ~bubble;
        rd_d         = bubble ? '0 : RD_E;
        result_src_d = result_src_e'(ResultSrcE);
        pc_plus4_d   = PCPlus4E;
        write_data_d = fwd_b;
        alu_result_d = (MulDivE && md_done) ? md_result : alu_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= RES_ALU;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            write_data_q <= write_data_d;
            alu_result_q <= alu_result_d;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign PCPlus4M    = pc_plus4_q;
    assign WriteDataM  = write_data_q;
    assign ALU_ResultM = alu_result_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus random
// ALU, branch and mul/div traffic against an arithmetic reference model.
module tb_execute_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MulDivE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [RAW-1:0]  RD_E;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            FlushE;
    logic [XLEN-1:0] PCTargetE;
    logic            PCSrcE, StallE, RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [RAW-1:0]  RD_M;
    logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int checks = 0;
    int errors = 0;

    execute_stage #(.XLEN(XLEN), .RAW(RAW), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst_n),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE), .MulDivE(MulDivE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .FlushE(FlushE),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallE(StallE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6:       return (a < b) ? 32'd1 : 32'd0;
            7:       return a << sh;
            8:       return a >> sh;
            9:       return 32'(int'(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_model(input int f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            0:       return a == b;
            1:       return a != b;
            4:       return int'(a) < int'(b);
            5:       return int'(a) >= int'(b);
            6:       return a < b;
            7:       return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_model(input int f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'(int'(a));
        sb  = longint'(int'(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            0: begin p = 64'(sa * sb); return p[31:0];  end
            1: begin p = 64'(sa * sb); return p[63:32]; end
            2: begin p = 64'(sa * ub); return p[63:32]; end
            3: begin p = 64'(ua * ub); return p[63:32]; end
            4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return 32'(int'(a) / int'(b));
            end
            5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; JalrE = 0;
        ALUSrcE = 0; MulDivE = 0; ResultSrcE = 0; ALUControlE = 0; Funct3E = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0; FlushE = 0;
    endtask

    // Issues one mul/div op now and follows it to write-back.
    task automatic run_md(input int f3, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp;
        int          cnt;
        logic        wr_bad;
        exp = md_model(f3, a, b);
        MulDivE = 1; Funct3E = 3'(f3); RD1_E = a; RD2_E = b; ForwardAE = 0; ForwardBE = 0;
        RegWriteE = 1; RD_E = 5'd7; ALUSrcE = 0; FlushE = 0;
        #1;
        cnt = 0; wr_bad = 0;
        while (StallE === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
            if (RegWriteM !== 1'b0) wr_bad = 1;
            if (StallE === 1'b1) begin
                ResultW = $urandom; ForwardAE = 2'b01; ForwardBE = 2'b01;
            end
        end
        checks++;
        if (cnt != 33) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected 33", name, cnt);
        end
        checks++;
        if (wr_bad) begin
            errors++;
            $display("FAIL %s stall_bubble: RegWriteM was not 0 during stall", name);
        end
        tick();
        checks++;
        if (ALU_ResultM !== exp || RegWriteM !== 1'b1 || RD_M !== 5'd7) begin
            errors++;
            $display("FAIL %s result: got %h wr=%b rd=%0d expected %h wr=1 rd=7",
                     name, ALU_ResultM, RegWriteM, RD_M, exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        RegWriteE = 1; MemWriteE = 1; BranchE = 1; RD1_E = 5; RD2_E = 5; Funct3E = 0;
        RD_E = 3; PCPlus4E = 32'h44; ResultSrcE = 2'b10;
        repeat (3) tick();
        checks++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {RegWriteM, MemWriteM, ResultSrcM, RD_M});
        end
        checks++;
        if (PCPlus4M !== 0 || WriteDataM !== 0 || ALU_ResultM !== 0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected 0", PCPlus4M, WriteDataM, ALU_ResultM);
        end
        checks++;
        if (PCSrcE !== 1'b0 || StallE !== 1'b0) begin
            errors++;
            $display("FAIL reset_pcsrc_stall: got %b %b expected 0 0", PCSrcE, StallE);
        end
        rst_n = 1;
        clear_inputs();
        RD1_E = 5; RD2_E = 7; RegWriteE = 1; RD_E = 1; ALUControlE = 0;
        tick();
        checks++;
        if (ALU_ResultM !== 32'd12 || RegWriteM !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_add: got %h wr=%b expected 0000000c wr=1", ALU_ResultM, RegWriteM);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RegWriteE = 1; RD_E = 2; ALUSrcE = 1; RD1_E = 32'h100; Imm_Ext_E = 0;
        tick();
        RD1_E = 1; ForwardAE = 2'b10; Imm_Ext_E = 4;
        tick();
        checks++;
        if (ALU_ResultM !== 32'h104) begin
            errors++; $display("FAIL fwd_a_mem: got %h expected 00000104", ALU_ResultM);
        end
        ForwardAE = 2'b01; ResultW = 32'h20;
        tick();
        checks++;
        if (ALU_ResultM !== 32'h24) begin
            errors++; $display("FAIL fwd_a_wb: got %h expected 00000024", ALU_ResultM);
        end
        ForwardAE = 2'b11;
        tick();
        checks++;
        if (ALU_ResultM !== 32'h5) begin
            errors++; $display("FAIL fwd_a_code11: got %h expected 00000005", ALU_ResultM);
        end
        ALUSrcE = 0; ForwardAE = 2'b00; RD1_E = 32'h10; RD2_E = 32'h99; ForwardBE = 2'b01; ResultW = 32'h33;
        tick();
        checks++;
        if (ALU_ResultM !== 32'h43 || WriteDataM !== 32'h33) begin
            errors++; $display("FAIL fwd_b_wb: got %h/%h expected 00000043/00000033", ALU_ResultM, WriteDataM);
        end
        RD1_E = 0; ForwardBE = 2'b10;
        tick();
        checks++;
        if (ALU_ResultM !== 32'h43 || WriteDataM !== 32'h43) begin
            errors++; $display("FAIL fwd_b_mem: got %h/%h expected 00000043/00000043", ALU_ResultM, WriteDataM);
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b, imm, pc4, exp;
        int          op;
        logic        src, mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        clear_inputs();
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 15); a = $urandom; b = $urandom; imm = $urandom;
            src = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
            rs = 2'($urandom_range(0, 2)); rd = 5'($urandom_range(1, 31)); pc4 = $urandom;
            exp = alu_model(op, a, src ? imm : b);
            ALUControlE = 4'(op); RD1_E = a; RD2_E = b; Imm_Ext_E = imm; ALUSrcE = src;
            RegWriteE = 1; MemWriteE = mw; ResultSrcE = rs; RD_E = rd; PCPlus4E = pc4;
            tick();
            checks++;
            if (ALU_ResultM !== exp) begin
                errors++;
                $display("FAIL alu_rand[%0d] op=%0d: got %h expected %h", i, op, ALU_ResultM, exp);
            end
            checks++;
            if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM} !== {1'b1, mw, rs, rd, pc4, b}) begin
                errors++;
                $display("FAIL alu_rand_fields[%0d]: got %b %b %b %0d %h %h expected 1 %b %b %0d %h %h",
                         i, RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, mw, rs, rd, pc4, b);
            end
        end
    endtask

    task automatic test_branches();
        logic [31:0] a, b, pc, imm;
        int          f3;
        clear_inputs();
        BranchE = 1; Funct3E = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
        #1;
        checks++;
        if (PCSrcE !== 1'b1) begin errors++; $display("FAIL blt_neg: got %b expected 1", PCSrcE); end
        Funct3E = 3'b110;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin errors++; $display("FAIL bltu_big: got %b expected 0", PCSrcE); end
        BranchE = 0; JalrE = 1; RD1_E = 32'h1001; Imm_Ext_E = 2; PCE = 32'h8000;
        #1;
        checks++;
        if (PCTargetE !== 32'h1002 || PCSrcE !== 1'b1) begin
            errors++; $display("FAIL jalr: got %h/%b expected 00001002/1", PCTargetE, PCSrcE);
        end
        JalrE = 0; JumpE = 1; PCE = 32'h400; Imm_Ext_E = 32'hFFFF_FFF8;
        #1;
        checks++;
        if (PCTargetE !== 32'h3F8 || PCSrcE !== 1'b1) begin
            errors++; $display("FAIL jal: got %h/%b expected 000003f8/1", PCTargetE, PCSrcE);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 30; i++) begin
            f3 = $urandom_range(0, 7); a = $urandom; pc = $urandom; imm = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            BranchE = 1; Funct3E = 3'(f3); RD1_E = a; RD2_E = b; PCE = pc; Imm_Ext_E = imm;
            #1;
            checks++;
            if (PCSrcE !== br_model(f3, a, b) || PCTargetE !== pc + imm) begin
                errors++;
                $display("FAIL br_rand[%0d] f3=%0d: got %b/%h expected %b/%h",
                         i, f3, PCSrcE, PCTargetE, br_model(f3, a, b), pc + imm);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_muldiv_directed();
        clear_inputs();
        run_md(1, 32'h8000_0000, 32'h2,         "mulh_min_x2");
        run_md(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1_m1");
        run_md(4, 32'd7,         32'd0,         "div_by_zero");
        run_md(6, 32'd7,         32'd0,         "rem_by_zero");
        run_md(4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_md(7, 32'hFFFF_FFFF, 32'h10,        "remu_f");
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        run_md(5, 32'd1000, 32'd9, "b2b_first");
        run_md(2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "b2b_second");
        clear_inputs();
        tick();
    endtask

    task automatic test_muldiv_random();
        logic [31:0] a, b;
        int          f3;
        for (int i = 0; i < 10; i++) begin
            f3 = $urandom_range(0, 7); a = $urandom; b = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                default: ;
            endcase
            run_md(f3, a, b, $sformatf("md_rand%0d_f%0d", i, f3));
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        clear_inputs();
        MulDivE = 1; Funct3E = 3'b100; RD1_E = 1000; RD2_E = 3; RegWriteE = 1; RD_E = 9;
        #1;
        repeat (10) tick();
        checks++;
        if (StallE !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", StallE); end
        FlushE = 1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (StallE !== 1'b0 || RegWriteM !== 1'b0 || RD_M !== 0) begin
            errors++; $display("FAIL abort_flush: got stall=%b wr=%b rd=%0d expected 0 0 0", StallE, RegWriteM, RD_M);
        end
        run_md(6, 32'hFFFF_FFF9, 32'd2, "after_flush_rem");

        clear_inputs();
        MulDivE = 1; Funct3E = 3'b100; RD1_E = 1000; RD2_E = 3; RegWriteE = 1; RD_E = 9;
        #1;
        repeat (5) tick();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (StallE !== 1'b0 || PCSrcE !== 1'b0 || RegWriteM !== 1'b0 || ALU_ResultM !== 0) begin
            errors++;
            $display("FAIL abort_reset: got stall=%b pcsrc=%b wr=%b res=%h expected 0 0 0 0",
                     StallE, PCSrcE, RegWriteM, ALU_ResultM);
        end
        clear_inputs();
        tick();
        rst_n = 1;
        run_md(5, 32'd100, 32'd7, "divu_after_reset");
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_forwarding();
        test_alu_random();
        test_branches();
        test_muldiv_directed();
        test_back_to_back();
        test_muldiv_random();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Parametrised RV32I/M execute stage between the decode/execute and memory pipeline registers. Adds the following over the single-cycle execute stage:
- operand forwarding;
- a full RISC-V branch-condition set plus JAL/JALR targets;
- a 4-bit ALU opcode;
- an iterative multiply/divide unit that stalls the pipeline.

Owns the E→M pipeline register, including stall and flush control.

## Interface
- XLEN, 32: datapath width (≥8, power of two)
- RAW, 5: register-address width
- MULDIV_EN, 1: 0 removes the mul/div unit; MulDivE is then ignored and StallE is tied 0
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MulDivE  in  1 each  decoded controls
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  in  4  ALU opcode
- Funct3E  in  3  branch condition, or mul/div op when MulDivE=1
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  operands
- RD_E  in  RAW  destination register
- ForwardAE, ForwardBE  in  2  00 register file, 01 ResultW, 10 ALU_ResultM
- ResultW  in  XLEN  write-back value
- FlushE  in  1  synchronous bubble/abort
- PCTargetE  out  XLEN  branch/jump target
- PCSrcE  out  1  redirect
- StallE  out  1  mul/div busy; upstream must hold all E inputs stable
- RegWriteM, MemWriteM  out  1 each
- ResultSrcM  out  2
- RD_M  out  RAW
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each

## Operation
**Forwarding and operands**
- SrcAE and forwarded B are selected by ForwardAE and ForwardBE; code 11 behaves as 00.
- SrcBE = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteDataM captures forwarded B.

**ALU**
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10–15 yield 0.
- Shift amount is SrcB[$clog2(XLEN)-1:0].

**Branch and jump**
- Funct3 conditions, computed on forwarded operands: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010 and 011 never taken.
- PCTargetE = JalrE ? ((SrcAE + Imm_Ext_E) & ~1) : PCE + Imm_Ext_E.
- PCSrcE = (BranchE & cond) | JumpE | JalrE, forced 0 while rst is low or StallE is high.

**Mul/div unit, Funct3 encoding**
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Operands are converted to magnitudes, iterated, then sign-corrected.
- Divide by zero: quotient all-ones, remainder = dividend.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.

**Mul/div state machine**
- IDLE: on MulDivE & ~FlushE, latch operands and op, set count = XLEN−1, go to BUSY.
- BUSY: one shift-add or restoring-subtract step per cycle. At count 0 go to DONE; otherwise decrement.
- DONE: result valid; go to IDLE.
- StallE = MulDivE & (state ≠ DONE).

**E→M register**
- When StallE is high, inserts a bubble: RegWriteM, MemWriteM and RD_M go to 0; data fields are don't-care.
- FlushE also inserts a bubble and returns the state machine to IDLE from any state, aborting the operation.
- Otherwise captures the ALU result, or the mul/div result when MulDivE=1.

**Reset**
- Every output register is 0; the state machine is IDLE with count 0.
- PCSrcE and StallE are 0 while rst is low.
- Reset asserted mid-operation discards the operation.

## Timing
- ALU, branch and jump: combinational in E; registered to M on the next edge (1-cycle latency).
- Mul/div issued in cycle 0:
  - StallE is high in cycles 0 through XLEN (XLEN+1 cycles).
  - DONE occurs in cycle XLEN+1 with StallE low.
  - The result appears on ALU_ResultM after the edge ending cycle XLEN+1.
- FlushE together with MulDivE in IDLE: the operation is not started.
- Back-to-back mul/div: the second issues in the cycle after DONE (the state machine is back in IDLE).
- Operands latched at issue are immune to changes in ForwardAE/ForwardBE or ResultW during BUSY.

## Structure
- Package execute_pkg holds:
  - alu_op_e, muldiv_op_e, br_cond_e, fwd_sel_e, result_src_e, md_state_e (IDLE/BUSY/DONE) enums;
  - ALU opcode constants.
- Sub-module muldiv_iter (parameter XLEN):
  - ports: clk, rst, start, abort, op, a, b, busy, done, result;
  - owns the state machine and counter.
- The ALU, forwarding muxes, branch comparator and pipeline register stay in execute_stage.

## Test plan
- Reset: hold rst low with RegWriteE=1, BranchE=1 and an equal comparison → all outputs 0, PCSrcE 0; after release, ADD 5+7 gives ALU_ResultM=12 one edge later.
- Forwarding: RD1_E=1, ALU_ResultM=0x100, ForwardAE=10, ADD imm 4 → 0x104. Repeat with ForwardAE=01 and ResultW=0x20 → 0x24.
- Branches:
  - BLT −1 vs 1 → PCSrcE=1.
  - BLTU 0xFFFFFFFF vs 1 → 0.
  - JALR with SrcA=0x1001 and imm 2 → PCTargetE=0x1002, PCSrcE=1.
- MUL/MULH: MULH 0x80000000 × 2 → StallE high for exactly 33 cycles, RegWriteM 0 during the stall, then ALU_ResultM=0xFFFFFFFF. MUL 0xFFFFFFFF × 0xFFFFFFFF → 1.
- Division corner cases:
  - DIV 7 / 0 → 0xFFFFFFFF.
  - REM 7 / 0 → 7.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REMU 0xFFFFFFFF / 0x10 → 0xF.
- Abort: FlushE in BUSY cycle 10 → next cycle StallE=0 and the state machine is IDLE, no write. Async reset mid-BUSY → same result, and the next DIVU 100/7 returns 14.
